sm83_regfile: RTL and testbench

//  Architectural register file of the SM83 core: the storage end of the register

---
 rtl/sm83_pkg.sv | 69 ++++++
 rtl/sm83_regfile_if.sv | 26 ++
 rtl/sm83_idu.sv | 20 ++
 rtl/sm83_regfile.sv | 110 +++++++++++
 tb/tb_sm83_regfile.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/sm83_pkg.sv
// Shared types for the SM83 register file and its IDU.
// Includes the write-enable vector, the register snapshot, the register selects and the IDU op/target codes.
package sm83_pkg;

    // Post-reset defaults for the program counter and the stack pointer.
    localparam logic [15:0] PC_RESET_DEF = 16'h0000;
    localparam logic [15:0] SP_RESET_DEF = 16'hFFFE;

    // One write-enable bit per target. ir is the MSB.
    typedef struct packed {
        logic ir;
        logic ie;
        logic a;
        logic f;
        logic gp8;
        logic gp16;
        logic pc;
        logic sp;
    } reg_wen_vec_t;

    // Snapshot of every architectural register.
    typedef struct packed {
        logic [7:0]  ir;
        logic [7:0]  ie;
        logic [7:0]  a;
        logic [7:0]  f;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [7:0]  d;
        logic [7:0]  e;
        logic [7:0]  h;
        logic [7:0]  l;
        logic [15:0] pc;
        logic [15:0] sp;
    } reg_vec_t;

    // Codes 6 and 7 are unused; a write with either code is dropped.
    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5
    } gp_r8_sel_t;

    // Code 3 is unused; a write with that code is dropped.
    typedef enum logic [1:0] {
        REG_BC = 2'd0,
        REG_DE = 2'd1,
        REG_HL = 2'd2
    } gp_r16_sel_t;

    typedef enum logic [1:0] {
        IDU_NONE = 2'd0,
        IDU_INC  = 2'd1,
        IDU_DEC  = 2'd2
    } idu_op_t;

    // Codes 5..7 are unused: the IDU outputs 0 and writes nothing back.
    typedef enum logic [2:0] {
        IDU_PC = 3'd0,
        IDU_SP = 3'd1,
        IDU_BC = 3'd2,
        IDU_DE = 3'd3,
        IDU_HL = 3'd4
    } idu_tgt_t;

endpackage

// File: rtl/sm83_regfile_if.sv
// Interface from the sequencer to the register file: write controls, IDU controls and register readback.
// master: drives wen/gp8_sel/gp16_sel/w8/w16/idu_op/idu_tgt and reads idu_out/regs. slave: the register file side.
interface sm83_regfile_if;
    import sm83_pkg::*;

    reg_wen_vec_t wen;
    gp_r8_sel_t   gp8_sel;
    gp_r16_sel_t  gp16_sel;
    logic [7:0]   w8;
    logic [15:0]  w16;
    idu_op_t      idu_op;
    idu_tgt_t     idu_tgt;
    logic [15:0]  idu_out;
    reg_vec_t     regs;

    modport master (
        output wen, gp8_sel, gp16_sel, w8, w16, idu_op, idu_tgt,
        input  idu_out, regs
    );

    modport slave (
        input  wen, gp8_sel, gp16_sel, w8, w16, idu_op, idu_tgt,
        output idu_out, regs
    );

endinterface

// File: rtl/sm83_idu.sv
// 16-bit increment/decrement unit. The result wraps modulo 2^16.
// Ports: d_i is the operand, op_i is the operation and q_o is the result. Any op other than INC or DEC passes the operand through.
module sm83_idu
    import sm83_pkg::*;
(
    input  logic [15:0] d_i,
    input  idu_op_t     op_i,
    output logic [15:0] q_o
);

    always_comb begin
        q_o = d_i;
        case (op_i)
            IDU_INC: q_o = d_i + 16'd1;
            IDU_DEC: q_o = d_i - 16'd1;
            default: q_o = d_i;
        endcase
    end

endmodule

// File: rtl/sm83_regfile.sv
// SM83 architectural register file with its IDU. Writes and IDU writeback take effect at the next clock edge.
// Ports: clk, rst (asynchronous, active-high) and bus (slave side of sm83_regfile_if).
module sm83_regfile
    import sm83_pkg::*;
#(
    parameter logic [15:0] PC_RESET = PC_RESET_DEF,
    parameter logic [15:0] SP_RESET = SP_RESET_DEF
) (
    input  logic           clk,
    input  logic           rst,
    sm83_regfile_if.slave  bus
);

    reg_vec_t    rv_q;
    reg_vec_t    rv_d;
    reg_vec_t    rv_out;
    logic [15:0] idu_src;
    logic [15:0] idu_res;
    logic        idu_tgt_ok;
    logic        idu_wb;

    // Select the IDU operand. The IDU always reads the value held before the edge.
    always_comb begin
        idu_src    = 16'h0000;
        idu_tgt_ok = 1'b1;
        case (bus.idu_tgt)
            IDU_PC:  idu_src = rv_q.pc;
            IDU_SP:  idu_src = rv_q.sp;
            IDU_BC:  idu_src = {rv_q.b, rv_q.c};
            IDU_DE:  idu_src = {rv_q.d, rv_q.e};
            IDU_HL:  idu_src = {rv_q.h, rv_q.l};
            default: idu_tgt_ok = 1'b0;
        endcase
    end

    sm83_idu u_idu (
        .d_i  (idu_src),
        .op_i (bus.idu_op),
        .q_o  (idu_res)
    );

    // Gate the result on an invalid target, because DEC of a zero operand would otherwise produce FFFF.
    assign bus.idu_out = idu_tgt_ok ? idu_res : 16'h0000;
    assign idu_wb = idu_tgt_ok &&
                    (bus.idu_op == IDU_INC || bus.idu_op == IDU_DEC);

    // Priority from lowest to highest is IDU writeback, then gp16, then gp8, then the other explicit writes.
    // Each later stage overwrites only the bytes it targets.
    always_comb begin
        rv_d = rv_q;

        if (idu_wb) begin
            case (bus.idu_tgt)
                IDU_PC:  rv_d.pc = idu_res;
                IDU_SP:  rv_d.sp = idu_res;
                IDU_BC:  {rv_d.b, rv_d.c} = idu_res;
                IDU_DE:  {rv_d.d, rv_d.e} = idu_res;
                IDU_HL:  {rv_d.h, rv_d.l} = idu_res;
                default: ;
            endcase
        end

        if (bus.wen.gp16) begin
            case (bus.gp16_sel)
                REG_BC:  {rv_d.b, rv_d.c} = bus.w16;
                REG_DE:  {rv_d.d, rv_d.e} = bus.w16;
                REG_HL:  {rv_d.h, rv_d.l} = bus.w16;
                default: ;
            endcase
        end

        if (bus.wen.gp8) begin
            case (bus.gp8_sel)
                REG_B:   rv_d.b = bus.w8;
                REG_C:   rv_d.c = bus.w8;
                REG_D:   rv_d.d = bus.w8;
                REG_E:   rv_d.e = bus.w8;
                REG_H:   rv_d.h = bus.w8;
                REG_L:   rv_d.l = bus.w8;
                default: ;
            endcase
        end

        if (bus.wen.ir) rv_d.ir = bus.w8;
        if (bus.wen.ie) rv_d.ie = bus.w8;
        if (bus.wen.a)  rv_d.a  = bus.w8;
        if (bus.wen.f)  rv_d.f  = {bus.w8[7:4], 4'h0};
        if (bus.wen.pc) rv_d.pc = bus.w16;
        if (bus.wen.sp) rv_d.sp = bus.w16;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q    <= '0;
            rv_q.pc <= PC_RESET;
            rv_q.sp <= SP_RESET;
        end else begin
            rv_q <= rv_d;
        end
    end

    // The low nibble of F reads as zero regardless of what was stored.
    always_comb begin
        rv_out        = rv_q;
        rv_out.f[3:0] = 4'h0;
    end

    assign bus.regs = rv_out;

endmodule

// File: tb/tb_sm83_regfile.sv
// Directed self-checking testbench for sm83_regfile.
// Expected register contents are hand-computed and tracked in exp_rv.
module tb_sm83_regfile;
    import sm83_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    reg_vec_t exp_rv;

    sm83_regfile_if bus ();

    sm83_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wen      = '0;
        bus.gp8_sel  = REG_B;
        bus.gp16_sel = REG_BC;
        bus.w8       = 8'h00;
        bus.w16      = 16'h0000;
        bus.idu_op   = IDU_NONE;
        bus.idu_tgt  = IDU_PC;
    endtask

    task automatic chk(input string tag, input logic [111:0] obs,
                       input logic [111:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic reg_vec_t reset_vec();
        reg_vec_t v;
        v    = '0;
        v.pc = 16'h0000;
        v.sp = 16'hFFFE;
        return v;
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle();
        exp_rv = reset_vec();
        repeat (2) tick();
        chk("reset_all", bus.regs, exp_rv);
        chk("reset_sp", {96'h0, bus.regs.sp}, {96'h0, 16'hFFFE});
        rst = 1'b0;
        tick();

        // gp8 write to E. The new value must not be visible before the edge.
        bus.wen.gp8 = 1'b1;
        bus.gp8_sel = REG_E;
        bus.w8      = 8'h5A;
        #1;
        chk("gp8_not_same_cycle", {104'h0, bus.regs.e}, 112'h0);
        tick();
        exp_rv.e = 8'h5A;
        chk("gp8_de", {96'h0, bus.regs.d, bus.regs.e}, {96'h0, 16'h005A});

        // Writes with an unused select code are dropped.
        bus.gp8_sel = gp_r8_sel_t'(3'd7);
        bus.w8      = 8'hFF;
        tick();
        chk("gp8_sel7_nop", bus.regs, exp_rv);
        idle();
        bus.wen.gp16 = 1'b1;
        bus.gp16_sel = gp_r16_sel_t'(2'd3);
        bus.w16      = 16'hFFFF;
        tick();
        chk("gp16_sel3_nop", bus.regs, exp_rv);

        // Same-cycle gp16 and gp8 writes to HL. The gp8 write overrides L.
        idle();
        bus.wen.gp16 = 1'b1;
        bus.wen.gp8  = 1'b1;
        bus.gp16_sel = REG_HL;
        bus.w16      = 16'h1234;
        bus.gp8_sel  = REG_L;
        bus.w8       = 8'hAB;
        tick();
        exp_rv.h = 8'h12;
        exp_rv.l = 8'hAB;
        chk("overlap_hl", bus.regs, exp_rv);

        // F write: the low nibble always reads as zero.
        idle();
        bus.wen.f = 1'b1;
        bus.w8    = 8'hFF;
        tick();
        exp_rv.f = 8'hF0;
        chk("f_ff", {104'h0, bus.regs.f}, {104'h0, 8'hF0});
        bus.wen.a = 1'b1;
        bus.w8    = 8'h3C;
        tick();
        exp_rv.a = 8'h3C;
        exp_rv.f = 8'h30;
        chk("a_f_same", bus.regs, exp_rv);

        // SP = 0000, then DEC wraps it to FFFF.
        idle();
        bus.wen.sp = 1'b1;
        bus.w16    = 16'h0000;
        tick();
        idle();
        bus.idu_op  = IDU_DEC;
        bus.idu_tgt = IDU_SP;
        #1;
        chk("idu_dec_out", {96'h0, bus.idu_out}, {96'h0, 16'hFFFF});
        tick();
        exp_rv.sp = 16'hFFFF;
        chk("idu_dec_sp", bus.regs, exp_rv);

        // PC = FFFF, then INC wraps it to 0000.
        idle();
        bus.wen.pc = 1'b1;
        bus.w16    = 16'hFFFF;
        tick();
        idle();
        bus.idu_op  = IDU_INC;
        bus.idu_tgt = IDU_PC;
        #1;
        chk("idu_inc_out", {96'h0, bus.idu_out}, 112'h0);
        tick();
        exp_rv.pc = 16'h0000;
        chk("idu_inc_pc", bus.regs, exp_rv);

        // An explicit PC write beats the IDU. The IDU still sees the pre-edge value.
        idle();
        bus.wen.pc = 1'b1;
        bus.w16    = 16'h0100;
        tick();
        bus.w16     = 16'hC000;
        bus.idu_op  = IDU_INC;
        bus.idu_tgt = IDU_PC;
        #1;
        chk("prio_idu_out", {96'h0, bus.idu_out}, {96'h0, 16'h0101});
        tick();
        exp_rv.pc = 16'hC000;
        chk("prio_pc", bus.regs, exp_rv);

        // IDU_NONE passes the register through and writes nothing back.
        idle();
        bus.idu_tgt = IDU_HL;
        #1;
        chk("idu_none_out", {96'h0, bus.idu_out}, {96'h0, 16'h12AB});
        tick();
        chk("idu_none_hold", bus.regs, exp_rv);

        // An invalid IDU target outputs 0 and writes nothing back.
        bus.idu_op  = IDU_DEC;
        bus.idu_tgt = idu_tgt_t'(3'd5);
        #1;
        chk("idu_bad_out", {96'h0, bus.idu_out}, 112'h0);
        tick();
        chk("idu_bad_hold", bus.regs, exp_rv);

        // IDU INC on DE with a gp8 write to D: E takes the IDU result.
        idle();
        bus.idu_op  = IDU_INC;
        bus.idu_tgt = IDU_DE;
        bus.wen.gp8 = 1'b1;
        bus.gp8_sel = REG_D;
        bus.w8      = 8'h77;
        tick();
        exp_rv.d = 8'h77;
        exp_rv.e = 8'h5B;
        chk("idu_gp8_split", bus.regs, exp_rv);

        // DEC on BC from 0000.
        idle();
        bus.idu_op  = IDU_DEC;
        bus.idu_tgt = IDU_BC;
        tick();
        exp_rv.b = 8'hFF;
        exp_rv.c = 8'hFF;
        chk("idu_dec_bc", bus.regs, exp_rv);

        // Several write enables in one cycle.
        idle();
        bus.wen.ir   = 1'b1;
        bus.wen.ie   = 1'b1;
        bus.wen.a    = 1'b1;
        bus.wen.gp16 = 1'b1;
        bus.wen.pc   = 1'b1;
        bus.wen.sp   = 1'b1;
        bus.gp16_sel = REG_DE;
        bus.w8       = 8'h11;
        bus.w16      = 16'hABCD;
        tick();
        exp_rv.ir = 8'h11;
        exp_rv.ie = 8'h11;
        exp_rv.a  = 8'h11;
        exp_rv.d  = 8'hAB;
        exp_rv.e  = 8'hCD;
        exp_rv.pc = 16'hABCD;
        exp_rv.sp = 16'hABCD;
        chk("multi_wen", bus.regs, exp_rv);

        // With every control idle, the registers hold.
        idle();
        tick();
        tick();
        chk("idle_hold", bus.regs, exp_rv);

        // A reset pulse in the middle of the run clears the registers immediately.
        rst = 1'b1;
        #1;
        exp_rv = reset_vec();
        chk("midrun_reset", bus.regs, exp_rv);
        tick();
        chk("reset_held", bus.regs, exp_rv);
        rst = 1'b0;
        tick();
        chk("post_reset", bus.regs, exp_rv);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
